// File: rtl/rob_param.sv
// rob_param: reorder buffer that allocates in program order, accepts ALU/load/store
// completions by tag, forwards DONE results and retires one entry per cycle in order.
module rob_param #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int XLEN  = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [OP_W-1:0]  alloc_op,
  input  logic [4:0]       alloc_rd,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             alloc_is_store,
  input  logic             alloc_done,
  input  logic [XLEN-1:0]  alloc_imm,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             alu_wb_valid,
  input  logic [TAG_W-1:0] alu_wb_tag,
  input  logic [XLEN-1:0]  alu_wb_value,
  input  logic             alu_wb_redirect,
  input  logic [XLEN-1:0]  alu_wb_target,
  input  logic             mem_wb_valid,
  input  logic [TAG_W-1:0] mem_wb_tag,
  input  logic [XLEN-1:0]  mem_wb_value,
  input  logic             st_ready_valid,
  input  logic [TAG_W-1:0] st_ready_tag,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_hit,
  output logic             q2_hit,
  output logic [XLEN-1:0]  q1_value,
  output logic [XLEN-1:0]  q2_value,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             ls_commit,
  output logic [TAG_W-1:0] ls_commit_tag,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [TAG_W:0]   count
);

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    ST_READY = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic            r_valid    [DEPTH];
  state_t          r_state    [DEPTH];
  logic [OP_W-1:0] r_op       [DEPTH];
  logic [4:0]      r_rd       [DEPTH];
  logic [XLEN-1:0] r_pc       [DEPTH];
  logic            r_is_store [DEPTH];
  logic [XLEN-1:0] r_value    [DEPTH];
  logic            r_redir    [DEPTH];
  logic [XLEN-1:0] r_target   [DEPTH];

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_commit_valid;
  logic [4:0]       r_commit_rd;
  logic [XLEN-1:0]  r_commit_value;
  logic [TAG_W-1:0] r_commit_tag;
  logic             r_ls_commit;
  logic [TAG_W-1:0] r_ls_commit_tag;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;

  logic [DEPTH-1:0] w_alu_hit;
  logic [DEPTH-1:0] w_mem_hit;
  logic [DEPTH-1:0] w_st_hit;
  logic             w_head_done;
  logic             w_head_st;
  logic             w_retire;
  logic             w_flush;
  logic             w_full;
  logic             w_alloc;
  logic             w_unused_fields;

  // Completion only lands on a live EXEC entry; the ALU port has priority over load and store-ready.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wb
      assign w_alu_hit[gi] = alu_wb_valid && (alu_wb_tag == TAG_W'(gi)) &&
                             r_valid[gi] && (r_state[gi] == EXEC);
      assign w_mem_hit[gi] = mem_wb_valid && (mem_wb_tag == TAG_W'(gi)) &&
                             r_valid[gi] && (r_state[gi] == EXEC) && !w_alu_hit[gi];
      assign w_st_hit[gi]  = st_ready_valid && (st_ready_tag == TAG_W'(gi)) &&
                             r_valid[gi] && (r_state[gi] == EXEC) &&
                             !w_alu_hit[gi] && !w_mem_hit[gi];
    end
  endgenerate

  assign w_head_done = r_valid[r_head] && (r_state[r_head] == DONE);
  assign w_head_st   = r_valid[r_head] && (r_state[r_head] == ST_READY);
  assign w_retire    = w_head_done || w_head_st;
  assign w_flush     = w_head_done && r_redir[r_head];
  assign w_full      = (r_count == FULL_CNT);
  assign w_alloc     = alloc_valid && !w_full;

  // op/pc/store-kind travel with the entry for observability; retirement does not consult them.
  assign w_unused_fields = ^{r_op[r_head], r_pc[r_head], r_is_store[r_head]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_state[i] <= EXEC;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_flush) begin
          r_valid[i] <= 1'b0;
        end else if (w_alloc && (r_tail == TAG_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_state[i] <= alloc_done ? DONE : EXEC;
        end else if (w_retire && (r_head == TAG_W'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (w_alu_hit[i] || w_mem_hit[i]) begin
          r_state[i] <= DONE;
        end else if (w_st_hit[i]) begin
          r_state[i] <= ST_READY;
        end
      end
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc && (r_tail == TAG_W'(i))) begin
        r_op[i]       <= alloc_op;
        r_rd[i]       <= alloc_rd;
        r_pc[i]       <= alloc_pc;
        r_is_store[i] <= alloc_is_store;
        r_value[i]    <= alloc_imm;
        r_redir[i]    <= 1'b0;
      end else if (w_alu_hit[i]) begin
        r_value[i]  <= alu_wb_value;
        r_redir[i]  <= alu_wb_redirect;
        r_target[i] <= alu_wb_target;
      end else if (w_mem_hit[i]) begin
        r_value[i] <= mem_wb_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_commit_valid   <= 1'b0;
      r_commit_rd      <= '0;
      r_commit_value   <= '0;
      r_commit_tag     <= '0;
      r_ls_commit      <= 1'b0;
      r_ls_commit_tag  <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_commit_valid   <= w_head_done && (r_rd[r_head] != 5'd0);
      r_ls_commit      <= w_head_st;
      r_redirect_valid <= w_flush;
      if (w_head_done && (r_rd[r_head] != 5'd0)) begin
        r_commit_rd    <= r_rd[r_head];
        r_commit_value <= r_value[r_head];
        r_commit_tag   <= r_head;
      end
      if (w_head_st) begin
        r_ls_commit_tag <= r_head;
      end
      if (w_flush) begin
        r_redirect_pc <= r_target[r_head];
      end
      // A redirect squashes everything younger, including a same-edge allocation.
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_retire) r_head <= r_head + 1'b1;
        if (w_alloc)  r_tail <= r_tail + 1'b1;
        if (w_alloc && !w_retire) begin
          r_count <= r_count + (TAG_W+1)'(1);
        end else if (!w_alloc && w_retire) begin
          r_count <= r_count - (TAG_W+1)'(1);
        end
      end
    end
  end

  assign alloc_ready    = !w_full;
  assign alloc_tag      = r_tail;
  assign count          = r_count;
  assign q1_hit         = r_valid[q1_tag] && (r_state[q1_tag] == DONE);
  assign q2_hit         = r_valid[q2_tag] && (r_state[q2_tag] == DONE);
  assign q1_value       = r_value[q1_tag];
  assign q2_value       = r_value[q2_tag];
  assign commit_valid   = r_commit_valid;
  assign commit_rd      = r_commit_rd;
  assign commit_value   = r_commit_value;
  assign commit_tag     = r_commit_tag;
  assign ls_commit      = r_ls_commit;
  assign ls_commit_tag  = r_ls_commit_tag;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed scenarios plus random traffic, checked against a
// queue-based program-order model of the reorder buffer.
module tb_rob_param;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int XLEN  = 32;
  localparam int OP_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic             alloc_valid, alloc_ready, alloc_is_store, alloc_done;
  logic [OP_W-1:0]  alloc_op;
  logic [4:0]       alloc_rd;
  logic [XLEN-1:0]  alloc_pc, alloc_imm;
  logic [TAG_W-1:0] alloc_tag;
  logic             alu_wb_valid, alu_wb_redirect;
  logic [TAG_W-1:0] alu_wb_tag;
  logic [XLEN-1:0]  alu_wb_value, alu_wb_target;
  logic             mem_wb_valid;
  logic [TAG_W-1:0] mem_wb_tag;
  logic [XLEN-1:0]  mem_wb_value;
  logic             st_ready_valid;
  logic [TAG_W-1:0] st_ready_tag;
  logic [TAG_W-1:0] q1_tag, q2_tag;
  logic             q1_hit, q2_hit;
  logic [XLEN-1:0]  q1_value, q2_value;
  logic             commit_valid, ls_commit, redirect_valid;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_value, redirect_pc;
  logic [TAG_W-1:0] commit_tag, ls_commit_tag;
  logic [TAG_W:0]   count;

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_is_store(alloc_is_store),
    .alloc_done(alloc_done), .alloc_imm(alloc_imm), .alloc_tag(alloc_tag),
    .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag), .alu_wb_value(alu_wb_value),
    .alu_wb_redirect(alu_wb_redirect), .alu_wb_target(alu_wb_target),
    .mem_wb_valid(mem_wb_valid), .mem_wb_tag(mem_wb_tag), .mem_wb_value(mem_wb_value),
    .st_ready_valid(st_ready_valid), .st_ready_tag(st_ready_tag),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .ls_commit(ls_commit), .ls_commit_tag(ls_commit_tag),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: program-order queue; st 0=executing, 1=store ready, 2=done.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [4:0]       rd;
    int               st;
    logic [XLEN-1:0]  value;
    bit               redir;
    logic [XLEN-1:0]  target;
  } ent_t;

  ent_t mq[$];
  int   mtail;
  bit               e_cv, e_ls, e_rv;
  logic [4:0]       e_crd;
  logic [XLEN-1:0]  e_cval, e_rpc;
  logic [TAG_W-1:0] e_ctag, e_lstag;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_tag(input logic [TAG_W-1:0] t);
    foreach (mq[k]) if (mq[k].tag == t) return k;
    return -1;
  endfunction

  task automatic model_clear();
    mq.delete();
    mtail = 0;
    e_cv = 0; e_ls = 0; e_rv = 0;
  endtask

  task automatic model_edge();
    bit   retire, flush, accept;
    int   idx;
    ent_t e;
    retire = 0; flush = 0;
    e_cv = 0; e_ls = 0; e_rv = 0;
    accept = alloc_valid && (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      e = mq[0];
      if (e.st == 2) begin
        retire = 1;
        if (e.rd != 0) begin
          e_cv = 1; e_crd = e.rd; e_cval = e.value; e_ctag = e.tag;
        end
        if (e.redir) begin
          flush = 1; e_rv = 1; e_rpc = e.target;
        end
      end else if (e.st == 1) begin
        retire = 1; e_ls = 1; e_lstag = e.tag;
      end
    end
    if (alu_wb_valid) begin
      idx = find_tag(alu_wb_tag);
      if (idx >= 0 && mq[idx].st == 0) begin
        e = mq[idx];
        e.value = alu_wb_value; e.redir = alu_wb_redirect; e.target = alu_wb_target; e.st = 2;
        mq[idx] = e;
      end
    end
    if (mem_wb_valid) begin
      idx = find_tag(mem_wb_tag);
      if (idx >= 0 && mq[idx].st == 0) begin
        e = mq[idx]; e.value = mem_wb_value; e.st = 2; mq[idx] = e;
      end
    end
    if (st_ready_valid) begin
      idx = find_tag(st_ready_tag);
      if (idx >= 0 && mq[idx].st == 0) begin
        e = mq[idx]; e.st = 1; mq[idx] = e;
      end
    end
    if (retire) void'(mq.pop_front());
    if (accept) begin
      e.tag = TAG_W'(mtail); e.rd = alloc_rd; e.st = alloc_done ? 2 : 0;
      e.value = alloc_imm; e.redir = 0; e.target = '0;
      mq.push_back(e);
      mtail = (mtail + 1) % DEPTH;
    end
    if (flush) begin
      mq.delete();
      mtail = 0;
    end
  endtask

  task automatic check_all();
    int  k;
    bit  h;
    chk("count", count, mq.size());
    chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
    chk("alloc_tag", alloc_tag, mtail);
    chk("commit_valid", commit_valid, e_cv);
    if (e_cv) begin
      chk("commit_rd", commit_rd, e_crd);
      chk("commit_value", commit_value, e_cval);
      chk("commit_tag", commit_tag, e_ctag);
    end
    chk("ls_commit", ls_commit, e_ls);
    if (e_ls) chk("ls_commit_tag", ls_commit_tag, e_lstag);
    chk("redirect_valid", redirect_valid, e_rv);
    if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
    k = find_tag(q1_tag);
    h = 0;
    if (k >= 0) h = (mq[k].st == 2);
    chk("q1_hit", q1_hit, h);
    if (h) chk("q1_value", q1_value, mq[k].value);
    k = find_tag(q2_tag);
    h = 0;
    if (k >= 0) h = (mq[k].st == 2);
    chk("q2_hit", q2_hit, h);
    if (h) chk("q2_value", q2_value, mq[k].value);
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_op = '0; alloc_rd = '0; alloc_pc = '0;
    alloc_is_store = 0; alloc_done = 0; alloc_imm = '0;
    alu_wb_valid = 0; alu_wb_tag = '0; alu_wb_value = '0;
    alu_wb_redirect = 0; alu_wb_target = '0;
    mem_wb_valid = 0; mem_wb_tag = '0; mem_wb_value = '0;
    st_ready_valid = 0; st_ready_tag = '0;
    q1_tag = '0; q2_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 0;
    idle();
    #1;
    model_clear();
    check_all();
    chk("rst_commit_rd", commit_rd, 0);
    chk("rst_commit_value", commit_value, 0);
    chk("rst_commit_tag", commit_tag, 0);
    chk("rst_ls_tag", ls_commit_tag, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic alloc(input logic [4:0] rd, input bit done, input logic [XLEN-1:0] imm,
                       input bit is_st);
    alloc_valid = 1; alloc_rd = rd; alloc_done = done; alloc_imm = imm;
    alloc_is_store = is_st; alloc_op = OP_W'($urandom); alloc_pc = $urandom;
  endtask

  function automatic logic [TAG_W-1:0] pick_tag();
    if (mq.size() > 0 && $urandom_range(0, 3) != 0)
      return mq[$urandom_range(0, mq.size() - 1)].tag;
    return TAG_W'($urandom);
  endfunction

  task automatic rand_inputs();
    idle();
    if ($urandom_range(0, 99) < 60)
      alloc(5'($urandom), $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0);
    alu_wb_valid = $urandom_range(0, 1);
    alu_wb_tag = pick_tag(); alu_wb_value = $urandom;
    alu_wb_redirect = ($urandom_range(0, 15) == 0); alu_wb_target = $urandom;
    mem_wb_valid = ($urandom_range(0, 9) < 3);
    mem_wb_tag = pick_tag(); mem_wb_value = $urandom;
    st_ready_valid = ($urandom_range(0, 9) < 2);
    st_ready_tag = pick_tag();
    q1_tag = TAG_W'($urandom); q2_tag = pick_tag();
  endtask

  initial begin
    idle();
    model_clear();
    #2;
    do_reset();

    // In-order retirement of out-of-order results
    alloc(5, 0, 0, 0); step();
    alloc(6, 0, 0, 0); step();
    alloc(7, 0, 0, 0); step();
    idle(); alu_wb_valid = 1; alu_wb_tag = 2; alu_wb_value = 32'h30; step();
    alu_wb_tag = 1; alu_wb_value = 32'h20; step();
    alu_wb_tag = 0; alu_wb_value = 32'h10; step();
    idle(); step();
    chk("t1_rd5", commit_rd, 5); chk("t1_v10", commit_value, 32'h10);
    step();
    chk("t1_rd6", commit_rd, 6); chk("t1_v20", commit_value, 32'h20);
    step();
    chk("t1_rd7", commit_rd, 7); chk("t1_v30", commit_value, 32'h30);
    chk("t1_empty", count, 0);

    // Full buffer and tail wrap
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alloc(5'(i + 1), 0, 0, 0); step();
    end
    chk("t2_tag7", alloc_tag, 7);
    step();
    chk("t2_full_ready", alloc_ready, 0); chk("t2_full_cnt", count, 8);
    chk("t2_wrap", alloc_tag, 0);
    step();
    chk("t2_no9th", count, 8);
    idle(); alu_wb_valid = 1; alu_wb_tag = 0; alu_wb_value = 32'h77; step();
    idle(); step();
    chk("t2_ready_again", alloc_ready, 1); chk("t2_cnt7", count, 7);
    chk("t2_commit", commit_value, 32'h77);

    // Redirect flush, with a discarded same-edge alloc and a stale writeback
    do_reset();
    alloc(1, 0, 0, 0); step();
    alloc(2, 0, 0, 0); step();
    alloc(3, 0, 0, 0); step();
    idle(); alu_wb_valid = 1; alu_wb_tag = 0; alu_wb_value = 32'h44;
    alu_wb_redirect = 1; alu_wb_target = 32'h100; step();
    idle(); alloc(4, 0, 0, 0); step();
    chk("t3_redir", redirect_valid, 1); chk("t3_pc", redirect_pc, 32'h100);
    chk("t3_cnt", count, 0); chk("t3_tag", alloc_tag, 0);
    idle(); alu_wb_valid = 1; alu_wb_tag = 1; alu_wb_value = 32'h99; step();
    idle(); step();
    chk("t3_stale", commit_valid, 0);

    // Store retirement then ALU retirement
    do_reset();
    alloc(0, 0, 0, 1); step();
    alloc(9, 0, 0, 0); step();
    idle(); st_ready_valid = 1; st_ready_tag = 0; step();
    idle(); alu_wb_valid = 1; alu_wb_tag = 1; alu_wb_value = 32'h55; step();
    chk("t4_ls", ls_commit, 1); chk("t4_ls_tag", ls_commit_tag, 0);
    idle(); step();
    chk("t4_cv", commit_valid, 1); chk("t4_val", commit_value, 32'h55);

    // Done-at-dispatch entry, forwarded before it retires
    do_reset();
    alloc(3, 1, 32'h12345000, 0); q1_tag = 0; step();
    chk("t5_qhit", q1_hit, 1); chk("t5_qval", q1_value, 32'h12345000);
    idle(); step();
    chk("t5_commit", commit_value, 32'h12345000); chk("t5_rd", commit_rd, 3);

    // ALU beats load on the same tag
    do_reset();
    alloc(4, 0, 0, 0); step();
    idle(); alu_wb_valid = 1; alu_wb_tag = 0; alu_wb_value = 32'hA;
    mem_wb_valid = 1; mem_wb_tag = 0; mem_wb_value = 32'hB; step();
    idle(); step();
    chk("t6_alu_wins", commit_value, 32'hA);

    // Random traffic, then an asynchronous reset mid-stream
    for (int i = 0; i < 400; i++) begin
      rand_inputs(); step();
    end
    #2;
    rst = 0;
    #1;
    chk("mr_cv", commit_valid, 0); chk("mr_ls", ls_commit, 0);
    chk("mr_rv", redirect_valid, 0); chk("mr_cnt", count, 0);
    chk("mr_val", commit_value, 0); chk("mr_rpc", redirect_pc, 0);
    model_clear();
    idle();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < 300; i++) begin
      rand_inputs(); step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer for the out-of-order core.
- Allocates entries in program order at dispatch and accepts results from the ALU and memory writeback ports.
- Serves operand forwarding lookups by tag.
- Retires one entry per cycle in order; a mispredicted or indirect control-flow entry triggers a full flush and PC redirect.

Parameters:
- DEPTH, 8, entry count; power of two, ≥2.
- TAG_W, $clog2(DEPTH), entry tag width.
- XLEN, 32, data/PC width.
- OP_W, 5, opcode field width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- alloc_valid  input  1  dispatch request.
- alloc_ready  output  1  entry free; high when count<DEPTH.
- alloc_op  input  OP_W  opcode stored with entry.
- alloc_rd  input  5  destination register.
- alloc_pc  input  XLEN  instruction PC.
- alloc_is_store  input  1  entry retires via store path.
- alloc_done  input  1  result known at dispatch (LUI-class).
- alloc_imm  input  XLEN  value used when alloc_done=1.
- alloc_tag  output  TAG_W  tag the current request will receive (= tail).
- alu_wb_valid  input  1  ALU result valid.
- alu_wb_tag  input  TAG_W  ALU result tag.
- alu_wb_value  input  XLEN  ALU result.
- alu_wb_redirect  input  1  control flow leaves the sequential path.
- alu_wb_target  input  XLEN  redirect target.
- mem_wb_valid  input  1  load result valid.
- mem_wb_tag  input  TAG_W  load result tag.
- mem_wb_value  input  XLEN  load result.
- st_ready_valid  input  1  store address/data resolved.
- st_ready_tag  input  TAG_W  store tag.
- q1_tag, q2_tag  input  TAG_W  forwarding lookups.
- q1_hit, q2_hit  output  1  entry valid and DONE.
- q1_value, q2_value  output  XLEN  entry value, combinational.
- commit_valid  output  1  register writeback retired; pulse.
- commit_rd  output  5  destination register.
- commit_value  output  XLEN  retired value.
- commit_tag  output  TAG_W  retired tag.
- ls_commit  output  1  store at head released to memory; pulse.
- ls_commit_tag  output  TAG_W  store tag.
- redirect_valid  output  1  flush + PC redirect; pulse.
- redirect_pc  output  XLEN  new fetch PC.
- count  output  TAG_W+1  occupied entries.

Behaviour:
- Reset (rst=0, async): head=tail=0, count=0, all entry valid bits cleared. commit_valid, ls_commit and redirect_valid are 0. commit_rd, commit_value, commit_tag, ls_commit_tag and redirect_pc are 0.
- Entry fields: valid, state {EXEC, ST_READY, DONE}, op, rd, pc, value, redir, target.
- Alloc: on an edge with alloc_valid & alloc_ready, write entry[tail] and set tail=tail+1 mod DEPTH (natural wrap).
  - state=DONE with value=alloc_imm if alloc_done, else EXEC.
  - redir=0.
- ALU writeback to a valid EXEC entry: value=alu_wb_value, redir=alu_wb_redirect, target=alu_wb_target, state=DONE.
- Mem writeback to a valid EXEC entry: value=mem_wb_value, state=DONE.
- Store ready: if state=EXEC, set state=ST_READY.
- Writebacks to invalid or non-EXEC entries are ignored. If the ALU and mem ports target the same tag in one cycle, ALU wins.
- Commit: evaluated each edge on registered head state; at most one retirement per cycle. Outputs are registered and valid the cycle after the deciding edge.
  - Head DONE, rd≠0: commit_valid=1 with rd, value, tag.
  - Head DONE, rd=0: retires silently (commit_valid=0).
  - Head ST_READY: ls_commit=1, ls_commit_tag=head; entry retires.
  - Any retirement: clear valid, head+1.
  - Head DONE & redir: additionally redirect_valid=1, redirect_pc=target. Same edge: all valid bits cleared, head=tail=0, count=0, and any alloc accepted on that edge is discarded.
- Latency: result written at edge N → earliest commit pulse after edge N+1. alloc_done entry allocated at edge N at an empty ROB → commit pulse after edge N+1.
- count: +1 on alloc, −1 on retire, unchanged when both happen. A flush forces 0.
- Full: count=DEPTH → alloc_ready=0. Retirement on the same edge does not admit an alloc that cycle.
- Empty: no commit activity; query hits are 0.
- Forwarding: qN_hit=valid[qN_tag] & state==DONE. Combinational; it sees only registered state, not same-cycle writebacks.
- Reset asserted mid-operation clears everything immediately. No pulse outputs are produced until the first edge after deassertion.

Test Plan:
- Reset, then allocate 3 entries (rd=5,6,7). ALU writes back tags 2,1,0 with 0x30,0x20,0x10 on consecutive cycles → commits in order rd5=0x10, rd6=0x20, rd7=0x30 on consecutive cycles. count returns to 0.
- DEPTH=8: allocate 8 entries with no writeback → alloc_ready=0 and count=8. A 9th alloc_valid is not accepted. Retire the head → alloc_ready=1 the next cycle, and alloc_tag wraps 7→0.
- Allocate a branch (tag0) and 2 younger entries. ALU wb tag0 with redirect=1, target=0x100 → redirect_valid=1 and redirect_pc=0x100. count=0 and alloc_tag=0 the following cycle. A younger-tag writeback after the flush is ignored.
- Allocate a store (tag0) and an ALU op (tag1). st_ready tag0, then ALU wb tag1=0x55 → ls_commit with tag0, then commit_valid with value 0x55.
- alloc_done=1, imm=0x12345000, rd=3 → commit_value=0x12345000 with no writeback. q1_tag=that entry before commit → q1_hit=1 and q1_value=0x12345000.
- ALU and mem writeback the same tag (0xA and 0xB) in one cycle → commits 0xA. Assert rst mid-stream → all outputs 0 and count=0 immediately.
